// File: rtl/shader_texel_fetch_pkg.sv
// rtl/shader_texel_fetch_pkg.sv - shared shader types and the texel wrap/address helper
// texel_addr is purely combinational so it can be exercised without the pipeline.
package shader_pkg;

  typedef enum logic {
    WRAP_REPEAT = 1'b0,
    WRAP_CLAMP  = 1'b1
  } wrap_mode_t;

  localparam int COORD_W  = 12;
  localparam int LOG2_MAX = 11;
  localparam int TADDR_W  = 32;

  function automatic logic [3:0] sat_log2(input logic [3:0] l);
    return (l > 4'(LOG2_MAX)) ? 4'(LOG2_MAX) : l;
  endfunction

  // Result is a full 32-bit sum; callers keep the low ADDR_W bits (mod 2^ADDR_W).
  function automatic logic [TADDR_W-1:0] texel_addr(
    input logic [TADDR_W-1:0] base,
    input logic [3:0]         wlog2,
    input logic [3:0]         hlog2,
    input wrap_mode_t         mode,
    input logic [COORD_W-1:0] tu,
    input logic [COORD_W-1:0] tv
  );
    logic [3:0]         wl;
    logic [3:0]         hl;
    logic [COORD_W-1:0] wmax;
    logic [COORD_W-1:0] hmax;
    logic [COORD_W-1:0] u;
    logic [COORD_W-1:0] v;
    wl   = sat_log2(wlog2);
    hl   = sat_log2(hlog2);
    wmax = (COORD_W'(1) << wl) - COORD_W'(1);
    hmax = (COORD_W'(1) << hl) - COORD_W'(1);
    if (mode == WRAP_CLAMP) begin
      u = (tu > wmax) ? wmax : tu;
      v = (tv > hmax) ? hmax : tv;
    end else begin
      u = tu & wmax;
      v = tv & hmax;
    end
    return base + (TADDR_W'(v) << wl) + TADDR_W'(u);
  endfunction

endpackage

// File: rtl/shader_texel_fetch_if.sv
// rtl/shader_texel_fetch_if.sv - config, coordinate, memory and texel-out signals of the fetch stage
interface shader_texel_fetch_if import shader_pkg::*; #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();

  logic               cfg_wen;
  logic [ADDR_W-1:0]  cfg_base;
  logic [3:0]         cfg_wlog2;
  logic [3:0]         cfg_hlog2;
  logic               cfg_mode;
  logic               cfg_busy;
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_tu;
  logic [COORD_W-1:0] in_tv;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_texel;
  logic               err_stray;

  modport master (
    output cfg_wen, cfg_base, cfg_wlog2, cfg_hlog2, cfg_mode,
    input  cfg_busy,
    output in_valid, in_tu, in_tv,
    input  in_ready,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_texel,
    output out_ready,
    input  err_stray
  );

  modport slave (
    input  cfg_wen, cfg_base, cfg_wlog2, cfg_hlog2, cfg_mode,
    output cfg_busy,
    input  in_valid, in_tu, in_tv,
    output in_ready,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_texel,
    input  out_ready,
    output err_stray
  );

endinterface

// File: rtl/shader_texel_fetch_fifo.sv
// rtl/shader_texel_fetch_fifo.sv - synchronous FIFO for returned texels, no fall-through
module shader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/shader_texel_fetch.sv
// rtl/shader_texel_fetch.sv - wraps texel coordinates, issues ordered texel reads, returns texels in order
module shader_texel_fetch import shader_pkg::*; #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int MAX_OUT = 4
) (
  input logic aclk,
  input logic areset,
  shader_texel_fetch_if.slave bus
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0]  cfg_base_q;
  logic [3:0]         cfg_wlog2_q;
  logic [3:0]         cfg_hlog2_q;
  wrap_mode_t         cfg_mode_q;
  logic               a_valid;
  logic [ADDR_W-1:0]  a_addr;
  logic [CW-1:0]      credits;
  logic [CW-1:0]      outstanding;
  logic               err_q;
  logic               busy;
  logic               in_ready_int;
  logic               in_fire;
  logic               issue;
  logic               out_fire;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_rdata;
  logic [TADDR_W-1:0] next_addr;
  logic               unused_addr_hi;

  assign next_addr = texel_addr(TADDR_W'(cfg_base_q), cfg_wlog2_q, cfg_hlog2_q,
                                cfg_mode_q, bus.in_tu, bus.in_tv);
  assign unused_addr_hi = ^next_addr[TADDR_W-1:ADDR_W];

  assign issue     = a_valid & bus.mem_gnt;
  assign out_fire  = ~fifo_empty & bus.out_ready;
  assign fifo_push = bus.mem_rvalid & (outstanding != '0) & ~fifo_full;
  assign busy      = a_valid | (outstanding != '0) | ~fifo_empty;

  // The request waiting in stage A is charged against the budget too, so a
  // granted request can never push credits past MAX_OUT.
  assign in_ready_int = ~areset & (~a_valid | bus.mem_gnt) &
                        (({1'b0, credits} + {{CW{1'b0}}, a_valid}) < (CW+1)'(MAX_OUT));
  assign in_fire = bus.in_valid & in_ready_int;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_base_q  <= '0;
      cfg_wlog2_q <= '0;
      cfg_hlog2_q <= '0;
      cfg_mode_q  <= WRAP_REPEAT;
      a_valid     <= 1'b0;
      a_addr      <= '0;
      credits     <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
    end else begin
      if (bus.cfg_wen && !busy) begin
        cfg_base_q  <= bus.cfg_base;
        cfg_wlog2_q <= sat_log2(bus.cfg_wlog2);
        cfg_hlog2_q <= sat_log2(bus.cfg_hlog2);
        cfg_mode_q  <= wrap_mode_t'(bus.cfg_mode);
      end

      if (in_fire) begin
        a_valid <= 1'b1;
        a_addr  <= next_addr[ADDR_W-1:0];
      end else if (issue) begin
        a_valid <= 1'b0;
      end

      if (issue && !out_fire)      credits <= credits + CW'(1);
      else if (!issue && out_fire) credits <= credits - CW'(1);

      if (issue && !fifo_push)      outstanding <= outstanding + CW'(1);
      else if (!issue && fifo_push) outstanding <= outstanding - CW'(1);

      if (bus.mem_rvalid && outstanding == '0) err_q <= 1'b1;
    end
  end

  shader_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (DATA_W)
  ) u_ret_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (fifo_push),
    .wdata (bus.mem_rdata),
    .pop   (out_fire),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.in_ready  = in_ready_int;
  assign bus.mem_req   = a_valid;
  assign bus.mem_addr  = a_addr;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_texel = fifo_rdata;
  assign bus.cfg_busy  = busy;
  assign bus.err_stray = err_q;

endmodule
